// File: rtl/piano_pkg.sv
// Shared constants, state encoding and helpers for the tile scroll engine.
package piano_pkg;

  localparam int NUM_ROWS = 6;
  localparam int ROW_H    = 40;

  localparam logic [5:0] OFFSET_MAX = 6'(ROW_H - 1);

  localparam logic [2:0] COL_NONE = 3'd0;
  localparam logic [2:0] COL_1    = 3'd1;
  localparam logic [2:0] COL_2    = 3'd2;
  localparam logic [2:0] COL_3    = 3'd3;
  localparam logic [2:0] COL_4    = 3'd4;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN_WAIT = 3'd1,
    ST_STEP     = 3'd2,
    ST_DRAW     = 3'd3,
    ST_DRAW_REL = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

  // A one-hot key pattern maps to its column code; anything else is no column
  function automatic logic [2:0] key_to_col(input logic [3:0] k);
    logic [2:0] col;
    case (k)
      4'b0001: col = COL_1;
      4'b0010: col = COL_2;
      4'b0100: col = COL_3;
      4'b1000: col = COL_4;
      default: col = COL_NONE;
    endcase
    return col;
  endfunction

  // New top-row tile: low two LFSR bits select one of the four columns
  function automatic logic [2:0] spawn_col(input logic [7:0] v);
    return {1'b0, v[1:0]} + 3'd1;
  endfunction

endpackage

// File: rtl/tile_lfsr.sv
// 8-bit Fibonacci LFSR used to pick the column of each newly spawned row.
module tile_lfsr
  import piano_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;
  logic       feedback;

  // Shift left with the tap parity fed into bit 0 whenever a step is requested
  always_comb begin
    feedback = ^(value_q & LFSR_TAPS);
    value_d  = value_q;
    if (step) begin
      value_d = {value_q[6:0], feedback};
    end
  end

  // Register the sequence; reset reloads the nonzero seed
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/tile_scroll_engine.sv
// Game-state engine: scrolls six tile rows, checks key hits on the bottom row,
// spawns rows from an LFSR and handshakes each redraw with the draw controller.
module tile_scroll_engine
  import piano_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [3:0]  key,
  input  logic        draw_done,
  output logic        draw_go,
  output logic [17:0] row_cols,
  output logic [5:0]  offset,
  output logic [7:0]  score,
  output logic        game_over,
  output logic [2:0]  state
);

  state_t                     state_q, state_d;
  logic [NUM_ROWS-1:0][2:0]   rows_q, rows_d;
  logic [5:0]                 offset_q, offset_d;
  logic [7:0]                 score_q, score_d;
  logic [3:0]                 pending_q, pending_d;
  logic                       over_flag_q, over_flag_d;
  logic                       draw_go_q, draw_go_d;
  logic                       game_over_q, game_over_d;

  logic                       lfsr_step;
  logic [7:0]                 lfsr_value;
  logic [2:0]                 hit_col;
  logic                       miss;
  logic [2:0]                 outgoing;

  tile_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  // Next-state logic for the game FSM, board, score and key latch
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    offset_d    = offset_q;
    score_d     = score_q;
    pending_d   = pending_q;
    over_flag_d = over_flag_q;
    lfsr_step   = 1'b0;
    hit_col     = key_to_col(pending_q);
    miss        = 1'b0;
    outgoing    = COL_NONE;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          rows_d      = '0;
          offset_d    = '0;
          score_d     = '0;
          pending_d   = '0;
          over_flag_d = 1'b0;
          state_d     = ST_DRAW;
        end
      end

      ST_RUN_WAIT: begin
        pending_d = pending_q | key;
        if (frame_tick) begin
          state_d = ST_STEP;
        end
      end

      ST_STEP: begin
        // Keys arriving now belong to the next step
        pending_d = key;
        if (pending_q != 4'b0000) begin
          if ((hit_col != COL_NONE) && (hit_col == rows_q[NUM_ROWS-1])) begin
            rows_d[NUM_ROWS-1] = COL_NONE;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end else begin
            miss = 1'b1;
          end
        end

        if (miss) begin
          over_flag_d = 1'b1;
          state_d     = ST_DRAW;
        end else if (offset_q < OFFSET_MAX) begin
          offset_d = offset_q + 6'd1;
          state_d  = ST_DRAW;
        end else begin
          outgoing = rows_d[NUM_ROWS-1];
          offset_d = '0;
          for (int r = 1; r < NUM_ROWS; r++) begin
            rows_d[r] = rows_q[r-1];
          end
          rows_d[0] = spawn_col(lfsr_value);
          lfsr_step = 1'b1;
          state_d   = (outgoing != COL_NONE) ? ST_OVER : ST_DRAW;
        end
      end

      ST_DRAW: begin
        pending_d = pending_q | key;
        if (draw_done) begin
          state_d = ST_DRAW_REL;
        end
      end

      ST_DRAW_REL: begin
        pending_d = pending_q | key;
        if (!draw_done) begin
          state_d = over_flag_q ? ST_OVER : ST_RUN_WAIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    draw_go_d   = (state_d == ST_DRAW);
    game_over_d = (state_d == ST_OVER);
  end

  // State and registered outputs, with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      offset_q    <= '0;
      score_q     <= '0;
      pending_q   <= '0;
      over_flag_q <= 1'b0;
      draw_go_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      offset_q    <= offset_d;
      score_q     <= score_d;
      pending_q   <= pending_d;
      over_flag_q <= over_flag_d;
      draw_go_q   <= draw_go_d;
      game_over_q <= game_over_d;
    end
  end

  assign draw_go   = draw_go_q;
  assign row_cols  = rows_q;
  assign offset    = offset_q;
  assign score     = score_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_tile_scroll_engine.sv
// Self-checking bench for tile_scroll_engine: table-driven scroll vectors,
// a game model feeding a scoreboard, and hand sequences for game-over paths.
module tb_tile_scroll_engine;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN_WAIT = 3'd1;
  localparam logic [2:0] S_DRAW     = 3'd3;
  localparam logic [2:0] S_OVER     = 3'd5;

  localparam int K_NORMAL = 0;
  localparam int K_MISS   = 1;
  localparam int K_LOSS   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        frame_tick;
  logic [3:0]  key;
  logic        draw_done;
  logic        draw_go;
  logic [17:0] row_cols;
  logic [5:0]  offset;
  logic [7:0]  score;
  logic        game_over;
  logic [2:0]  state;

  tile_scroll_engine #(
    .LFSR_SEED (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .key        (key),
    .draw_done  (draw_done),
    .draw_go    (draw_go),
    .row_cols   (row_cols),
    .offset     (offset),
    .score      (score),
    .game_over  (game_over),
    .state      (state)
  );

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  typedef struct {
    logic [17:0] rows;
    logic [5:0]  off;
    logic [7:0]  score;
  } exp_t;

  typedef struct {
    logic [3:0] key;
    logic [5:0] exp_off;
    logic [2:0] exp_row0;
    logic [7:0] exp_score;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[40];

  int         vectors;
  int         miscompares;
  int         m_rows[6];
  int         m_offset;
  int         m_score;
  logic [7:0] m_lfsr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] packRows();
    logic [17:0] p;
    p = '0;
    for (int r = 0; r < 6; r++) p[3*r +: 3] = m_rows[r][2:0];
    return p;
  endfunction

  task automatic pushExpect();
    exp_t e;
    e.rows  = packRows();
    e.off   = m_offset[5:0];
    e.score = m_score[7:0];
    sb.push_back(e);
  endtask

  task automatic compareScoreboard(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: scoreboard empty, got rows %0h, expected an entry", tag, row_cols);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_rows"}, row_cols, e.rows);
      checkOutput({tag, "_offset"}, offset, e.off);
      checkOutput({tag, "_score"}, score, e.score);
    end
  endtask

  task automatic modelClear();
    for (int r = 0; r < 6; r++) m_rows[r] = 0;
    m_offset = 0;
    m_score  = 0;
  endtask

  // One scroll step of the reference game; pushes the board the redraw must show
  task automatic modelStep(input logic [3:0] pend, output int kind);
    int  col;
    bit  loss;
    logic fb;
    kind = K_NORMAL;
    if (pend != 4'b0000) begin
      col = 0;
      for (int i = 0; i < 4; i++) if (pend[i]) col = i + 1;
      if ($countones(pend) == 1 && m_rows[5] != 0 && col == m_rows[5]) begin
        m_rows[5] = 0;
        if (m_score < 255) m_score++;
      end else begin
        kind = K_MISS;
      end
    end
    if (kind == K_NORMAL) begin
      if (m_offset < 39) begin
        m_offset++;
      end else begin
        loss = (m_rows[5] != 0);
        for (int r = 5; r > 0; r--) m_rows[r] = m_rows[r-1];
        m_rows[0] = int'(m_lfsr[1:0]) + 1;
        fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
        m_offset = 0;
        if (loss) kind = K_LOSS;
      end
    end
    pushExpect();
  endtask

  function automatic logic [3:0] autoKey();
    logic [3:0] k;
    k = 4'b0000;
    if (m_rows[5] != 0) k[m_rows[5]-1] = 1'b1;
    return k;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_draw_go"}, draw_go, 1'b0);
    checkOutput({tag, "_rows"}, row_cols, 18'd0);
    checkOutput({tag, "_offset"}, offset, 6'd0);
    checkOutput({tag, "_score"}, score, 8'd0);
    checkOutput({tag, "_game_over"}, game_over, 1'b0);
    checkOutput({tag, "_state"}, state, S_IDLE);
  endtask

  // Tick from RUN_WAIT and wait for the redraw request (or the direct loss)
  task automatic tickToGo(input int kind);
    int lat;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    if (kind == K_LOSS) begin
      @(negedge clock);
      checkOutput("loss_state", state, S_OVER);
      checkOutput("loss_game_over", game_over, 1'b1);
      checkOutput("loss_draw_go", draw_go, 1'b0);
      compareScoreboard("loss");
    end else begin
      lat = 1;
      while (draw_go !== 1'b1 && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      checkOutput("tick_to_go_cycles", lat, 2);
      compareScoreboard("frame");
    end
  endtask

  // Two-phase draw handshake, then confirm where the FSM settled
  task automatic finishDraw(input int kind);
    int n;
    draw_done = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (draw_go === 1'b1 && n < 20);
    checkOutput("go_drop_cycles", n, 1);
    draw_done = 1'b0;
    @(negedge clock);
    checkOutput("after_draw_state", state, (kind == K_MISS) ? S_OVER : S_RUN_WAIT);
    checkOutput("after_draw_game_over", game_over, (kind == K_MISS) ? 1'b1 : 1'b0);
  endtask

  task automatic applyStimulus(input logic [3:0] k, output int kind);
    if (k != 4'b0000) begin
      key = k;
      @(negedge clock);
      key = 4'b0000;
    end
    modelStep(k, kind);
    tickToGo(kind);
    if (kind != K_LOSS) finishDraw(kind);
  endtask

  task automatic startGame(input string tag);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    modelClear();
    pushExpect();
    checkOutput({tag, "_draw_go"}, draw_go, 1'b1);
    checkOutput({tag, "_game_over"}, game_over, 1'b0);
    compareScoreboard(tag);
    finishDraw(K_NORMAL);
  endtask

  initial begin
    int kind;
    int n;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    frame_tick  = 1'b0;
    key         = 4'b0000;
    draw_done   = 1'b0;
    m_lfsr      = 8'hA5;
    modelClear();

    for (int i = 0; i < 40; i++) begin
      vecs[i].key       = 4'b0000;
      vecs[i].exp_off   = 6'((i + 1) % 40);
      vecs[i].exp_row0  = (i == 39) ? 3'd2 : 3'd0;
      vecs[i].exp_score = 8'd0;
    end

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkResetOutputs("reset");

    // Keys and ticks in IDLE are ignored
    key = 4'b0001;
    frame_tick = 1'b1;
    @(negedge clock);
    key = 4'b0000;
    frame_tick = 1'b0;
    checkOutput("idle_ignore_state", state, S_IDLE);

    startGame("start1");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(vecs[i].key, kind);
      checkOutput("vec_offset", offset, vecs[i].exp_off);
      checkOutput("vec_row0", row_cols[2:0], vecs[i].exp_row0);
      checkOutput("vec_score", score, vecs[i].exp_score);
    end

    // Play until the second tile (column 3) reaches the hit row, then hit it
    n = 0;
    while (m_rows[5] != 3 && n < 400) begin
      applyStimulus(autoKey(), kind);
      n++;
    end
    checkOutput("row5_is_3", row_cols[17:15], 3'd3);
    applyStimulus(4'b0100, kind);
    checkOutput("hit_row5_cleared", row_cols[17:15], 3'd0);
    checkOutput("hit_score", score, 8'd2);
    checkOutput("hit_no_over", game_over, 1'b0);

    // Next column-3 tile: wrong key ends the game after one final redraw
    n = 0;
    while (m_rows[5] != 3 && n < 400) begin
      applyStimulus(autoKey(), kind);
      n++;
    end
    checkOutput("row5_is_3_again", row_cols[17:15], 3'd3);
    applyStimulus(4'b0001, kind);
    checkOutput("miss_game_over", game_over, 1'b1);
    checkOutput("miss_score", score, 8'd3);
    repeat (5) @(negedge clock);
    checkOutput("over_hold_rows", row_cols, packRows());
    checkOutput("over_hold_offset", offset, m_offset[5:0]);
    checkOutput("over_hold_state", state, S_OVER);

    // Second game: no keys, the first tile leaves row 5 unhit
    startGame("start2");
    kind = K_NORMAL;
    n = 0;
    while (kind != K_LOSS && n < 400) begin
      applyStimulus(4'b0000, kind);
      n++;
    end
    checkOutput("wrap_loss_frames", n, 280);

    // Third game: stall the draw controller while ticks arrive
    startGame("start3");
    modelStep(4'b0000, kind);
    tickToGo(kind);
    for (int t = 0; t < 5; t++) begin
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      repeat (19) @(negedge clock);
      checkOutput("stall_draw_go", draw_go, 1'b1);
      checkOutput("stall_offset", offset, 6'd1);
      checkOutput("stall_state", state, S_DRAW);
    end
    finishDraw(kind);
    applyStimulus(4'b0000, kind);

    // Keep hitting every tile until the score saturates
    n = 0;
    while (m_score < 255 && n < 12000) begin
      applyStimulus(autoKey(), kind);
      n++;
    end
    checkOutput("score_reached_255", score, 8'd255);
    n = 0;
    while (m_rows[5] == 0 && n < 100) begin
      applyStimulus(4'b0000, kind);
      n++;
    end
    applyStimulus(autoKey(), kind);
    checkOutput("sat_score", score, 8'd255);
    checkOutput("sat_row5_cleared", row_cols[17:15], 3'd0);
    checkOutput("sat_no_over", game_over, 1'b0);

    // Reset in the middle of a redraw
    modelStep(4'b0000, kind);
    tickToGo(kind);
    reset = 1'b1;
    @(negedge clock);
    checkResetOutputs("mid_draw_reset");
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_state", state, S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tile_scroll_engine.md
# tile_scroll_engine

Game-state engine that sits directly upstream of the column draw controller. Holds the six on-screen tile rows (3-bit column codes), advances a vertical scroll offset once per frame tick, evaluates player key hits against the bottom row, and spawns new top rows from an LFSR. After every scroll step it raises `draw_go` and holds it until the draw controller reports completion, so row codes and offset stay frozen during each redraw.

## Interface
- `NUM_ROWS`, 6, visible tile rows; row 0 is top, row 5 is bottom (hit row).
- `ROW_H`, 40, row height in pixels; offset range 0..ROW_H-1.
- `LFSR_SEED`, 8'hA5, nonzero reset value of the spawn LFSR.

- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse; begins a game from IDLE or OVER.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `key`  in  4  one-cycle pulses, already debounced; bit i selects column code i+1.
- `draw_done`  in  1  drawing-done level from the draw controller.
- `draw_go`  out  1  redraw request; level, not pulse.
- `row_cols`  out  18  row r code at bits [3r+2:3r]; 0 means empty, 1..4 means tile column.
- `offset`  out  6  scroll offset added to each row's y (line_id*40 + offset).
- `score`  out  8  hits, saturating at 255.
- `game_over`  out  1  high in OVER.
- `state`  out  3  current FSM state, for debug/LEDs.

## Operation
- Reset values: all rows 0, `offset`=0, `score`=0, `draw_go`=0, `game_over`=0, key latch 0, LFSR=`LFSR_SEED`, state IDLE.
- States: IDLE, RUN_WAIT, STEP, DRAW, DRAW_REL, OVER.
- IDLE: on `start`, clear rows/offset/score, go to DRAW (initial blank frame).
- RUN_WAIT: on `frame_tick`, go to STEP. Ticks arriving in any other state are dropped.
- Key latch: in RUN_WAIT, STEP, DRAW and DRAW_REL, any nonzero `key` ORs into a 4-bit pending register. The latch is consumed and cleared in STEP. Keys in IDLE and OVER are ignored.
- STEP (one cycle), evaluated in this order:
  1. Hit check, only if pending is nonzero.
     - Hit: pending is one-hot with column c equal to row 5's code (nonzero). Row 5 is cleared to 0 and `score` increments (saturating).
     - Miss: multiple bits set, column mismatch, or row 5 empty. Go to OVER; no shift occurs.
  2. Advance:
     - If `offset` < ROW_H-1: `offset`+1.
     - Else wrap: `offset`=0 and rows shift down (row r takes row r-1). If the outgoing row 5 is still nonzero after the hit check, go to OVER.
     - On wrap, new row 0 = {1'b0, lfsr[1:0]} + 1, giving 1..4, and the LFSR steps once.
  3. Go to DRAW.
- DRAW: `draw_go`=1; on `draw_done`=1 go to DRAW_REL.
- DRAW_REL: `draw_go`=0; on `draw_done`=0 go to RUN_WAIT, or to OVER if the game-over flag is set.
- OVER: `game_over`=1; rows, offset and score are held.
  - On `start`: clear the board and go to DRAW.
  - If the transition into OVER came from a STEP miss, first perform one final DRAW/DRAW_REL so the frozen board is shown; the flag is carried in a register.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifting left with feedback into bit 0. It never loads zero.
- Widths: `offset` is a 6-bit compare against ROW_H-1; `score` uses an 8-bit adder with a saturate guard.

## Timing
- `frame_tick` to `draw_go` rise: 2 cycles (RUN_WAIT→STEP, STEP→DRAW; `draw_go` is registered).
- `row_cols`/`offset` change only on the STEP clock edge or on start/reset. They are stable for the entire time `draw_go` is high.
- Handshake: `draw_go` rises → wait for `draw_done` high → drop `draw_go` → wait for `draw_done` low. No new STEP until both phases complete.
- `reset` mid-draw: `draw_go` falls the next cycle. The draw controller is reset by the same source.
- `start` during RUN states is ignored.
- A key pulse coinciding with the STEP cycle is latched for the next STEP, not the current one.

## Structure
- Package `piano_pkg`: `NUM_ROWS`, `ROW_H`, column codes `COL_NONE`=0 and `COL_1`..`COL_4`=1..4, FSM state enum (3-bit), LFSR tap constant.
- Sub-module `tile_lfsr` (clock, reset, step, seed parameter, 8-bit value out). All other logic is in the top FSM.

## Test plan
- Reset then `start` → `draw_go` rises within 2 cycles; rows all 0, `offset`=0. Ack with `draw_done` 1 then 0 → state RUN_WAIT.
- 40 frame ticks each followed by a draw handshake → `offset` runs 0..39 then 0. At the wrap, row 0 = (LFSR_SEED[1:0])+1 = 2 for seed A5, and the LFSR steps to its next value.
- Row 5=3, `key`=4'b0100 before a tick → row 5 becomes 0, `score`=1, no game over. `key`=4'b0001 instead → `game_over`=1 after one final draw handshake.
- Row 5=2 unhit at wrap (offset 39 and tick) → OVER. `start` → score 0, rows 0, `draw_go` reasserted.
- Hold `draw_done`=0 for 100 cycles while issuing 5 frame ticks → `draw_go` stays 1, `offset` is unchanged, and the ticks are dropped.
- Score at 255 plus a hit → `score` stays 255. `reset` during DRAW → next cycle all outputs are at reset values.
